// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: datapath width, default imem depth, loader state encoding.
package lc2k_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned IMEM_DEPTH  = 16;
    localparam int unsigned IMEM_ADDR_W = $clog2(IMEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FILL   = 3'd2,
        RUN    = 3'd3,
        HALTED = 3'd4
    } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: streams a program into instruction memory, zero-fills the tail,
// then releases the CPU from reset until it halts or an abort is requested.
module imem_loader
    import lc2k_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    loadLen,
    input  logic               abort,
    input  logic               inValid,
    input  logic [INSTR_W-1:0] inData,
    output logic               inReady,
    output logic               memWe,
    output logic [ADDR_W-1:0]  memAddr,
    output logic [INSTR_W-1:0] memWData,
    output logic               cpuReset,
    input  logic               cpuHalt,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    wordCount
);

    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ld_state_e            state_q, state_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W:0]      count_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic                 we_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [INSTR_W-1:0]   wdata_d;
    logic                 error_d;
    logic                 cpu_reset_d;
    logic                 len_ok;
    logic [ADDR_W:0]      count_inc;

    // Status decodes straight off the state register; inReady must not depend on inValid.
    assign inReady   = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == FILL);
    assign done      = (state_q == HALTED);
    assign len_ok    = (loadLen != '0) && (loadLen <= LEN_MAX);
    assign count_inc = wordCount + (ADDR_W+1)'(1);

    // Next-state, pointer/count and write-port decode; abort overrides everything.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = wordCount;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = memAddr;
        wdata_d = memWData;
        error_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, HALTED: begin
                    if (start) begin
                        if (len_ok) begin
                            len_d   = loadLen;
                            count_d = '0;
                            ptr_d   = '0;
                            state_d = LOAD;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (inValid) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = inData;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        count_d = count_inc;
                        if (count_inc == len_q) begin
                            state_d = (len_q == LEN_MAX) ? RUN : FILL;
                        end
                    end
                end
                FILL: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = '0;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    if (ptr_q == LAST_ADDR) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cpuHalt) begin
                        state_d = HALTED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Release only once RUN has lasted a full cycle, so the final write lands first.
        cpu_reset_d = !((state_q == RUN) && (state_d == RUN));
    end

    // State, counters and registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            wordCount <= '0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
            cpuReset  <= 1'b1;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            wordCount <= count_d;
            memWe     <= we_d;
            memAddr   <= addr_d;
            memWData  <= wdata_d;
            cpuReset  <= cpu_reset_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;
    import lc2k_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [ADDR_W:0]    loadLen;
    logic               abort;
    logic               inValid;
    logic [INSTR_W-1:0] inData;
    logic               inReady;
    logic               memWe;
    logic [ADDR_W-1:0]  memAddr;
    logic [INSTR_W-1:0] memWData;
    logic               cpuReset;
    logic               cpuHalt;
    logic               busy;
    logic               done;
    logic               error;
    logic [ADDR_W:0]    wordCount;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .loadLen(loadLen), .abort(abort),
        .inValid(inValid), .inData(inData), .inReady(inReady), .memWe(memWe),
        .memAddr(memAddr), .memWData(memWData), .cpuReset(cpuReset), .cpuHalt(cpuHalt),
        .busy(busy), .done(done), .error(error), .wordCount(wordCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic push_zeros(input int from);
        for (int a = from; a < int'(DEPTH); a++) push(ADDR_W'(a), '0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_inReady"}, 64'(inReady), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_cpuReset"}, 64'(cpuReset), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_idle(tag);
        chk({tag, "_memWe"}, 64'(memWe), 64'd0);
        chk({tag, "_memAddr"}, 64'(memAddr), 64'd0);
        chk({tag, "_memWData"}, 64'(memWData), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_wordCount"}, 64'(wordCount), 64'd0);
    endtask

    task automatic wait_run(input string tag, input int budget);
        int n = 0;
        while (cpuReset !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_reached_run"}, 64'(cpuReset), 64'd0);
    endtask

    // Scoreboard: every write on the memory port must match the next expected write.
    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {28'd0, memAddr, memWData}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", 64'(memAddr), 64'(w.addr));
                chk("write_data", 64'(memWData), 64'(w.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [INSTR_W-1:0] words [7];
        int hs;
        logic prev_hs;
        logic tog;

        words[0] = 32'd8519687;  words[1] = 32'd22216704; words[2] = 32'd16777219;
        words[3] = 32'd29360128; words[4] = 32'd29360128; words[5] = 32'd1179649;
        words[6] = 32'd25165824;

        reset = 1'b1; start = 1'b0; loadLen = '0; abort = 1'b0;
        inValid = 1'b0; inData = '0; cpuHalt = 1'b0;
        step(); step();
        check_reset_vals("por");
        reset = 1'b0;
        step();

        // Nominal load, loadLen=7, inValid held high.
        start = 1'b1; loadLen = 5'd7; inValid = 1'b1; inData = words[0];
        step();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk($sformatf("nom_we_c%0d", c), 64'(memWe), 64'((c >= 2) && (c <= 17)));
            chk($sformatf("nom_cpuReset_c%0d", c), 64'(cpuReset), 64'(c < 18));
            chk($sformatf("nom_inReady_c%0d", c), 64'(inReady), 64'(c <= 7));
            if (c <= 7) begin
                inData = words[c-1];
                push(ADDR_W'(c-1), words[c-1]);
                if (c == 7) push_zeros(7);
            end else begin
                inValid = 1'b0;
            end
            step();
        end
        chk("nom_wordCount", 64'(wordCount), 64'd7);
        chk("nom_sb_empty", 64'(exp_q.size()), 64'd0);

        // Halt, then reload 2 words from HALTED.
        cpuHalt = 1'b1;
        step();
        cpuHalt = 1'b0;
        chk("halt_done", 64'(done), 64'd1);
        chk("halt_cpuReset", 64'(cpuReset), 64'd1);
        chk("halt_busy", 64'(busy), 64'd0);
        chk("halt_wordCount_held", 64'(wordCount), 64'd7);
        start = 1'b1; loadLen = 5'd2;
        step();
        start = 1'b0;
        chk("reload_wordCount_cleared", 64'(wordCount), 64'd0);
        chk("reload_busy", 64'(busy), 64'd1);
        chk("reload_done", 64'(done), 64'd0);
        inValid = 1'b1; inData = 32'h0123_4567; push(4'd0, inData);
        step();
        inData = 32'h89AB_CDEF; push(4'd1, inData); push_zeros(2);
        step();
        inValid = 1'b0;
        wait_run("reload", 40);
        chk("reload_wordCount", 64'(wordCount), 64'd2);

        // Abort from RUN, then full-depth load with inValid toggling.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_run");
        start = 1'b1; loadLen = 5'd16;
        step();
        start = 1'b0;
        hs = 0; prev_hs = 1'b0; tog = 1'b1;
        for (int c = 0; c < 80 && hs < 16; c++) begin
            chk("full_we_after_hs", 64'(memWe), 64'(prev_hs));
            inValid = tog;
            tog = !tog;
            inData = $urandom;
            prev_hs = inValid && inReady;
            if (prev_hs) begin
                push(ADDR_W'(hs), inData);
                hs++;
            end
            step();
        end
        inValid = 1'b0;
        chk("full_hs_count", 64'(hs), 64'd16);
        chk("full_last_we", 64'(memWe), 64'd1);
        chk("full_no_fill", 64'(busy), 64'd0);
        chk("full_cpuReset_still_high", 64'(cpuReset), 64'd1);
        step();
        chk("full_no_extra_we", 64'(memWe), 64'd0);
        chk("full_cpuReset_low", 64'(cpuReset), 64'd0);
        chk("full_wordCount", 64'(wordCount), 64'd16);

        // Illegal lengths from IDLE.
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; loadLen = (k == 0) ? 5'd0 : 5'd17;
            step();
            start = 1'b0;
            chk($sformatf("illegal%0d_error", k), 64'(error), 64'd1);
            chk($sformatf("illegal%0d_busy", k), 64'(busy), 64'd0);
            chk($sformatf("illegal%0d_we", k), 64'(memWe), 64'd0);
            step();
            chk($sformatf("illegal%0d_error_pulse", k), 64'(error), 64'd0);
            chk($sformatf("illegal%0d_wordCount", k), 64'(wordCount), 64'd16);
            check_idle($sformatf("illegal%0d", k));
        end

        // Abort together with the 4th handshake of a 10-word load.
        start = 1'b1; loadLen = 5'd10;
        step();
        start = 1'b0;
        inValid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            inData = 32'hA000_0000 + 32'(c);
            if (c < 4) push(ADDR_W'(c-1), inData);
            else abort = 1'b1;
            step();
        end
        abort = 1'b0; inValid = 1'b0;
        check_idle("abort_load");
        chk("abort_load_wordCount", 64'(wordCount), 64'd3);
        chk("abort_load_we", 64'(memWe), 64'd0);
        step(); step();
        chk("abort_load_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted during FILL.
        start = 1'b1; loadLen = 5'd4;
        step();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin
                inValid = 1'b1;
                inData = 32'hB000_0000 + 32'(c);
                push(ADDR_W'(c-1), inData);
            end else begin
                inValid = 1'b0;
            end
            if (c >= 5 && c <= 6) push(ADDR_W'(c-1), '0);
            if (c == 7) begin
                chk("fill_busy_before_reset", 64'(busy), 64'd1);
                reset = 1'b1;
            end
            step();
        end
        reset = 1'b0;
        check_reset_vals("fill_reset");
        for (int c = 0; c < 4; c++) begin
            chk("fill_reset_no_we", 64'(memWe), 64'd0);
            step();
        end
        start = 1'b1; loadLen = 5'd1;
        step();
        start = 1'b0;
        chk("after_reset_start_busy", 64'(busy), 64'd1);
        chk("after_reset_inReady", 64'(inReady), 64'd1);
        inValid = 1'b1; inData = 32'hC0DE_0001; push(4'd0, inData); push_zeros(1);
        step();
        inValid = 1'b0;
        wait_run("after_reset", 40);
        chk("after_reset_wordCount", 64'(wordCount), 64'd1);

        step(); step();
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot/load controller for the LC2K instruction memory. Accepts a program as a valid/ready stream of 32-bit words and writes it into the writable instruction memory from address 0. Zero-fills the unused tail, then releases the CPU from reset. Returns to a quiescent state when the CPU halts or an abort is requested. Sits between the host/test loader and the instruction memory write port, and drives the CPU's reset.

## Interface
- DEPTH, 16, instruction memory words.
- ADDR_W, 4, address width; must equal clog2(DEPTH).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin load session; sampled only in IDLE or HALTED.
- loadLen  in  ADDR_W+1  number of program words, legal 1..DEPTH; sampled with start.
- abort  in  1  return to IDLE from any state.
- inValid  in  1  stream word valid.
- inData  in  32  stream word.
- inReady  out  1  loader can accept; high only in LOAD.
- memWe  out  1  instruction memory write enable, registered.
- memAddr  out  ADDR_W  write address, registered.
- memWData  out  32  write data, registered.
- cpuReset  out  1  active-high CPU reset; low only in RUN.
- cpuHalt  in  1  CPU executed halt; sampled only in RUN.
- busy  out  1  state is LOAD or FILL.
- done  out  1  state is HALTED.
- error  out  1  one-cycle pulse on illegal loadLen.
- wordCount  out  ADDR_W+1  words accepted this session; held until next accepted start.

## Operation
- States: IDLE, LOAD, FILL, RUN, HALTED.
- IDLE/HALTED + start, loadLen in 1..DEPTH: latch loadLen, clear wordCount and address pointer, go to LOAD.
- IDLE/HALTED + start with loadLen 0 or >DEPTH: pulse error, stay put, wordCount unchanged.
- LOAD: inReady=1. Each handshake (inValid & inReady):
  - registers memWe=1, memAddr=pointer, memWData=inData for the next cycle;
  - increments pointer and wordCount.
  - On the loadLen-th handshake, go to FILL if loadLen<DEPTH, otherwise go to RUN.
- FILL: inReady=0. One zero write per cycle to addresses loadLen..DEPTH-1. After the write to DEPTH-1 is issued, go to RUN.
- RUN: cpuReset=0. cpuHalt=1 -> HALTED; cpuReset returns to 1 the next cycle.
- abort, any state: go to IDLE next cycle.
  - Any write already registered still completes.
  - Partially loaded memory is not cleared.
  - abort beats start, cpuHalt, and a simultaneous handshake; that word is not accepted and wordCount is not incremented.
- start outside IDLE/HALTED is ignored.
- memWe is 0 in every cycle that carries no write.

## Timing
- Reset values:
  - state IDLE;
  - inReady=0, memWe=0, memAddr=0, memWData=0;
  - cpuReset=1, busy=0, done=0, error=0, wordCount=0.
- Write latency is one cycle: word accepted in cycle t is on the memory port in cycle t+1.
- cpuReset falls the first cycle after the final memWe cycle, so the final write commits before the CPU fetches.
- With start accepted at the end of cycle 0 and inValid held high:
  - handshakes occur in cycles 1..N;
  - data writes occur in cycles 2..N+1;
  - zero writes occur in cycles N+2..DEPTH+1;
  - cpuReset=0 from cycle DEPTH+2.
  - The total is independent of N.
- inValid low stalls LOAD indefinitely with no writes. The stream can stall without limit.
- inReady is a combinational decode of state (LOAD). It is not a function of inValid.
- error is asserted the cycle after the illegal start.

## Structure
- Shared package lc2k_pkg holds:
  - INSTR_W=32;
  - the loader state encoding (IDLE, LOAD, FILL, RUN, HALTED);
  - the default DEPTH.
- Single flat module: state register, pointer/count register, registered write port. No sub-module needed.
- The instruction memory itself is outside this block. The integrating top muxes this write port with the CPU's read port.

## Test plan
- Nominal load, DEPTH=16, loadLen=7, words 8519687, 22216704, 16777219, 29360128, 29360128, 1179649, 25165824, inValid always high:
  - addresses 0..6 written with those words in cycles 2..8;
  - zeros to addresses 7..15 in cycles 9..17;
  - cpuReset=0 at cycle 18;
  - wordCount=7.
- Full load, loadLen=16, inValid toggled every other cycle:
  - 16 writes at addresses 0..15, each one cycle after its handshake;
  - no FILL cycles;
  - cpuReset falls one cycle after the last write.
- Illegal length:
  - start with loadLen=0 -> error pulses 1 cycle, state stays IDLE, no writes;
  - then start with loadLen=17 -> same.
- Abort mid-load, loadLen=10: assert abort together with the 4th handshake.
  - only addresses 0..2 are written;
  - wordCount=3;
  - IDLE next cycle, inReady=0, cpuReset=1.
- Halt and reload:
  - in RUN assert cpuHalt -> done=1 and cpuReset=1 next cycle;
  - then start with loadLen=2 from HALTED -> new load proceeds and wordCount is cleared to 0 first.
- Reset mid-FILL:
  - assert reset during a FILL cycle -> next cycle all outputs at their reset values;
  - no further writes;
  - start is then accepted normally.
